// File: rtl/hit_scan_pkg.sv
// hit_scan_pkg: shared FSM encoding and result-word layout for the hit scan sequencer
package hit_scan_pkg;

    localparam int DEF_COUNT_W = 20;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ARM,
        WAIT_CLR,
        WAIT_RDY,
        PUSH,
        NEXT,
        DONE
    } state_t;

    // Result word is {timeout, sat, step, count}, count in the low bits
    localparam int COUNT_LSB = 0;

    function automatic int step_lsb(input int count_w);
        return count_w;
    endfunction

    function automatic int sat_bit(input int count_w, input int step_w);
        return count_w + step_w;
    endfunction

    function automatic int tmo_bit(input int count_w, input int step_w);
        return count_w + step_w + 1;
    endfunction

endpackage

// File: rtl/hit_scan_result_fifo.sv
// hit_scan_result_fifo: synchronous result FIFO with flush; head word reads as zero when empty
module hit_scan_result_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4
) (
    input  logic             clk40M,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; a write into a full FIFO is legal when a read frees a slot
    always_ff @(posedge clk40M) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_wr ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_rd ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

    // Storage array; contents are don't-care while empty because the output is masked
    always_ff @(posedge clk40M) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/hit_scan_sequencer.sv
// hit_scan_sequencer: steps a setting through a scan, fires one statistic window per step, streams results
module hit_scan_sequencer
    import hit_scan_pkg::*;
#(
    parameter int NUM_STEPS  = 16,
    parameter int STEP_W     = 4,
    parameter int COUNT_W    = DEF_COUNT_W,
    parameter int SETTLE_CYC = 400,
    parameter int TIMEOUT_W  = 26,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk40M,
    input  logic                        reset_n,
    input  logic                        scan_start,
    input  logic                        scan_abort,
    output logic [STEP_W-1:0]           step_index,
    output logic                        stat_start,
    input  logic                        stat_ready,
    input  logic [COUNT_W-1:0]          stat_count,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [2+STEP_W+COUNT_W-1:0] res_data,
    output logic                        scan_busy,
    output logic                        scan_done,
    output logic                        timeout_err
);

    localparam int RES_W    = 2 + STEP_W + COUNT_W;
    localparam int STEP_LSB = step_lsb(COUNT_W);
    localparam int SAT_BIT  = sat_bit(COUNT_W, STEP_W);
    localparam int TMO_BIT  = tmo_bit(COUNT_W, STEP_W);
    localparam int SET_W    = $clog2(SETTLE_CYC) + 1;

    state_t             state;
    logic               armed;
    logic               start_edge;
    logic               last_step;
    logic [SET_W-1:0]   settle_cnt;
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic [RES_W-1:0]   entry;
    logic               full;
    logic               empty;
    logic               wr_en;
    logic               rd_en;

    function automatic logic [RES_W-1:0] pack(input logic tmo, input logic [STEP_W-1:0] stp,
                                              input logic [COUNT_W-1:0] cnt);
        logic [RES_W-1:0] w;
        w                         = '0;
        w[TMO_BIT]                = tmo;
        w[SAT_BIT]                = !tmo && (&cnt);
        w[STEP_LSB +: STEP_W]     = stp;
        w[COUNT_LSB +: COUNT_W]   = cnt;
        return w;
    endfunction

    assign start_edge = scan_start && armed;
    assign last_step  = step_index == STEP_W'(NUM_STEPS - 1);
    assign res_valid  = !empty;
    assign rd_en      = res_valid && res_ready;
    assign wr_en      = (state == PUSH) && (!full || rd_en);

    // armed means scan_start was seen low last cycle; clearing it in reset keeps a held-high start from firing
    always_ff @(posedge clk40M) begin
        if (!reset_n) armed <= 1'b0;
        else armed <= !scan_start;
    end

    // Scan FSM with settle/timeout counters, result capture and registered control outputs
    always_ff @(posedge clk40M) begin
        if (!reset_n) begin
            state       <= IDLE;
            step_index  <= '0;
            stat_start  <= 1'b0;
            scan_busy   <= 1'b0;
            scan_done   <= 1'b0;
            timeout_err <= 1'b0;
            settle_cnt  <= '0;
            tmo_cnt     <= '0;
            entry       <= '0;
        end else if (scan_abort) begin
            state      <= IDLE;
            step_index <= '0;
            stat_start <= 1'b0;
            scan_busy  <= 1'b0;
            scan_done  <= 1'b0;
        end else begin
            stat_start <= 1'b0;
            scan_done  <= 1'b0;
            case (state)
                IDLE, DONE: if (start_edge) begin
                    state       <= SETTLE;
                    step_index  <= '0;
                    timeout_err <= 1'b0;
                    settle_cnt  <= '0;
                    scan_busy   <= 1'b1;
                end
                SETTLE: if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
                    state      <= ARM;
                    stat_start <= 1'b1;
                end else begin
                    settle_cnt <= settle_cnt + SET_W'(1);
                end
                ARM: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_CLR;
                end
                WAIT_CLR: begin
                    tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
                    if (tmo_cnt == '1) begin
                        entry       <= pack(1'b1, step_index, '0);
                        timeout_err <= 1'b1;
                        state       <= PUSH;
                    end else if (!stat_ready) begin
                        state <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
                    if (stat_ready) begin
                        entry <= pack(1'b0, step_index, stat_count);
                        state <= PUSH;
                    end else if (tmo_cnt == '1) begin
                        entry       <= pack(1'b1, step_index, '0);
                        timeout_err <= 1'b1;
                        state       <= PUSH;
                    end
                end
                PUSH: if (wr_en) state <= NEXT;
                NEXT: if (last_step) begin
                    state     <= DONE;
                    scan_done <= 1'b1;
                    scan_busy <= 1'b0;
                end else begin
                    step_index <= step_index + STEP_W'(1);
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    hit_scan_result_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk40M  (clk40M),
        .reset_n (reset_n),
        .flush   (scan_abort),
        .wr_en   (wr_en),
        .wr_data (entry),
        .full    (full),
        .rd_en   (rd_en),
        .rd_data (res_data),
        .empty   (empty)
    );

endmodule

// File: tb/tb_hit_scan_sequencer.sv
// tb_hit_scan_sequencer: scoreboard bench with a behavioural statistic-block model
module tb_hit_scan_sequencer;

    localparam int NUM_STEPS  = 6;
    localparam int STEP_W     = 4;
    localparam int COUNT_W    = 20;
    localparam int SETTLE_CYC = 10;
    localparam int TIMEOUT_W  = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int RES_W      = 2 + STEP_W + COUNT_W;

    logic               clk40M = 1'b0;
    logic               reset_n;
    logic               scan_start;
    logic               scan_abort;
    logic [STEP_W-1:0]  step_index;
    logic               stat_start;
    logic               stat_ready;
    logic [COUNT_W-1:0] stat_count;
    logic               res_valid;
    logic               res_ready;
    logic [RES_W-1:0]   res_data;
    logic               scan_busy;
    logic               scan_done;
    logic               timeout_err;

    int tests = 0;
    int fails = 0;
    int starts = 0;
    int dones = 0;
    int s0;
    int d0;
    int stp;
    int m_delay = 100;
    int m_hold = 0;
    int m_never = -1;
    bit m_sat = 1'b0;
    logic prev_ss = 1'b0;
    logic [RES_W-1:0] exp_q[$];

    hit_scan_sequencer #(
        .NUM_STEPS  (NUM_STEPS),
        .STEP_W     (STEP_W),
        .COUNT_W    (COUNT_W),
        .SETTLE_CYC (SETTLE_CYC),
        .TIMEOUT_W  (TIMEOUT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk40M      (clk40M),
        .reset_n     (reset_n),
        .scan_start  (scan_start),
        .scan_abort  (scan_abort),
        .step_index  (step_index),
        .stat_start  (stat_start),
        .stat_ready  (stat_ready),
        .stat_count  (stat_count),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .scan_busy   (scan_busy),
        .scan_done   (scan_done),
        .timeout_err (timeout_err)
    );

    always #5 clk40M = ~clk40M;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RES_W-1:0] mk(input bit t, input bit s, input int st, input int c);
        return {t, s, STEP_W'(st), COUNT_W'(c)};
    endfunction

    task automatic push_scan(input int never, input bit sat);
        for (int i = 0; i < NUM_STEPS; i++)
            exp_q.push_back(i == never ? mk(1, 0, i, 0) : sat ? mk(0, 1, i, 'hFFFFF) : mk(0, 0, i, i * 10));
    endtask

    task automatic start_scan();
        @(posedge clk40M); #1 scan_start = 1'b1;
        @(posedge clk40M); #1 scan_start = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk40M);
            n++;
        end
        check(name, exp_q.size(), 0);
        repeat (5) @(posedge clk40M);
        #1;
    endtask

    task automatic wait_starts(input string name, input int target, input int budget);
        int n = 0;
        while (starts - s0 < target && n < budget) begin
            @(posedge clk40M);
            n++;
        end
        check(name, 64'(starts - s0 >= target), 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " step_index"}, step_index, 0);
        check({tag, " stat_start"}, stat_start, 0);
        check({tag, " res_valid"}, res_valid, 0);
        check({tag, " res_data"}, res_data, 0);
        check({tag, " scan_busy"}, scan_busy, 0);
        check({tag, " scan_done"}, scan_done, 0);
        check({tag, " timeout_err"}, timeout_err, 0);
    endtask

    // Monitor: start pulse width, done pulses, and scoreboard pops on every accepted result
    always @(negedge clk40M) begin
        if (stat_start) begin
            starts++;
            check("stat_start pulse width", prev_ss, 0);
        end
        prev_ss = stat_start;
        if (scan_done) dones++;
        if (reset_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected result: got %0h, none expected", res_data);
            end else begin
                check("result", res_data, exp_q.pop_front());
            end
        end
    end

    // Statistic block model: drops ready after m_hold cycles, reports step*10 after m_delay cycles
    initial begin
        stat_ready = 1'b0;
        stat_count = '0;
        forever begin
            @(negedge clk40M);
            if (stat_start && reset_n) begin
                stp = int'(step_index);
                @(posedge clk40M);
                repeat (m_hold) @(posedge clk40M);
                #1 stat_ready = 1'b0;
                if (stp != m_never) begin
                    repeat (m_delay) @(posedge clk40M);
                    #1;
                    stat_count = m_sat ? '1 : COUNT_W'(stp * 10);
                    stat_ready = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        scan_start = 1'b0;
        scan_abort = 1'b0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk40M);
        @(negedge clk40M);
        check_reset_vals("reset");
        @(posedge clk40M); #1 reset_n = 1'b1;

        // Plain scan, sink always ready
        s0 = starts; d0 = dones;
        push_scan(-1, 0);
        start_scan();
        @(negedge clk40M);
        check("t1 busy", scan_busy, 1);
        drain("t1 drain", 3000);
        check("t1 done pulses", dones - d0, 1);
        check("t1 stat_start pulses", starts - s0, NUM_STEPS);
        check("t1 busy after", scan_busy, 0);
        check("t1 timeout_err", timeout_err, 0);

        // Back-pressure: FSM must stall in PUSH once the FIFO is full
        res_ready = 1'b0;
        s0 = starts; d0 = dones;
        push_scan(-1, 0);
        start_scan();
        repeat (900) @(posedge clk40M);
        @(negedge clk40M);
        check("t2 stall starts", starts - s0, FIFO_DEPTH + 1);
        check("t2 stall step", step_index, FIFO_DEPTH);
        check("t2 stall busy", scan_busy, 1);
        check("t2 stall valid", res_valid, 1);
        @(posedge clk40M); #1 res_ready = 1'b1;
        drain("t2 drain", 3000);
        check("t2 done pulses", dones - d0, 1);

        // Statistic block never answers at step 1
        m_never = 1;
        d0 = dones;
        push_scan(1, 0);
        start_scan();
        drain("t3 drain", 4000);
        check("t3 timeout_err", timeout_err, 1);
        check("t3 done pulses", dones - d0, 1);
        m_never = -1;

        // Saturated counts with stale ready held into WAIT_CLR
        m_sat = 1'b1;
        m_hold = 5;
        d0 = dones;
        push_scan(-1, 1);
        start_scan();
        @(negedge clk40M);
        check("t4 timeout_err cleared", timeout_err, 0);
        drain("t4 drain", 3000);
        check("t4 done pulses", dones - d0, 1);
        m_sat = 1'b0;
        m_hold = 0;

        // Abort during WAIT_RDY at step 2
        res_ready = 1'b0;
        s0 = starts; d0 = dones;
        start_scan();
        wait_starts("t5 reach step 2", 3, 1000);
        repeat (20) @(posedge clk40M);
        @(negedge clk40M);
        check("t5 pre step", step_index, 2);
        check("t5 pre valid", res_valid, 1);
        @(posedge clk40M); #1 scan_abort = 1'b1;
        @(posedge clk40M); #1 scan_abort = 1'b0;
        @(negedge clk40M);
        check("t5 busy", scan_busy, 0);
        check("t5 valid", res_valid, 0);
        check("t5 data", res_data, 0);
        check("t5 step", step_index, 0);
        repeat (150) @(posedge clk40M);
        @(negedge clk40M);
        check("t5 no done", dones - d0, 0);
        check("t5 still idle", scan_busy, 0);
        @(posedge clk40M); #1 res_ready = 1'b1;
        push_scan(-1, 0);
        start_scan();
        drain("t5 restart drain", 3000);
        check("t5 restart done", dones - d0, 1);

        // Reset mid-scan with scan_start held high through release
        s0 = starts; d0 = dones;
        exp_q.push_back(mk(0, 0, 0, 0));
        start_scan();
        wait_starts("t6 reach step 1", 2, 1000);
        repeat (20) @(posedge clk40M);
        #1 reset_n = 1'b0;
        scan_start = 1'b1;
        @(posedge clk40M);
        @(negedge clk40M);
        check_reset_vals("t6 reset");
        check("t6 step0 delivered", exp_q.size(), 0);
        repeat (2) @(posedge clk40M);
        #1 reset_n = 1'b1;
        s0 = starts;
        repeat (120) @(posedge clk40M);
        @(negedge clk40M);
        check("t6 held start ignored", scan_busy, 0);
        check("t6 no stat_start", starts - s0, 0);
        @(posedge clk40M); #1 scan_start = 1'b0;
        d0 = dones;
        push_scan(-1, 0);
        start_scan();
        drain("t6 restart drain", 3000);
        check("t6 restart done", dones - d0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
